multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Control sequencer for the multicycle MIPS datapath: shares one ALU and one unified instruction/data memory across the cycles of each instruction. A Moore FSM steps through fetch, decode, execute, memory and writeback states. It drives every datapath enable and mux select, and stalls on a memory-ready handshake. It sits beside the ALU decoder inside the controller and replaces the single-cycle opcode decode.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock, all state on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- op  in  6  opcode field of the instruction register
- funct  in  6  funct field of the instruction register
- mem_ready  in  1  memory has completed the current access
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- irwrite  out  1  load instruction register
- pcwrite  out  1  unconditional PC write
- branch  out  1  PC write qualified by ALU zero (datapath ANDs with zero)
- pcsrc  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- alusrca  out  1  0 = PC, 1 = register A
- alusrcb  out  2  00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
- alucontrol  out  3  ALU operation from the ALU decoder
- memwrite  out  1  memory write strobe
- regwrite  out  1  register file write
- regdst  out  1  0 = rt, 1 = rd
- memtoreg  out  1  0 = ALUOut, 1 = Data register
- instr_done  out  1  one-cycle pulse in the final cycle of each retired instruction
- illegal  out  1  sticky: an unsupported opcode was decoded

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT.
- Supported opcodes: R-type 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
- Unlisted output signals are 0 in each state. aluop 00 = add, 01 = sub, 10 = use funct.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. irwrite=pcwrite=mem_ready. Stay in FETCH while mem_ready=0, else go to DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by op:
  - LW or SW -> MEMADR
  - R-type -> EXECUTE
  - BEQ -> BRANCH
  - ADDI -> ADDIEX
  - J -> JUMP
  - any other opcode -> HALT
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Go to MEMRD for LW, MEMWR for SW.
- MEMRD: iord=1. Stay while mem_ready=0, else go to MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1, instr_done=1. Go to FETCH.
- MEMWR: iord=1, memwrite=1 held for the whole state. instr_done=mem_ready. Go to FETCH on mem_ready.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10. Go to ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0, instr_done=1. Go to FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1, instr_done=1. Go to FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Go to ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0, instr_done=1. Go to FETCH.
- JUMP: pcsrc=10, pcwrite=1, instr_done=1. Go to FETCH.
- HALT: illegal=1 and all enables 0. HALT is absorbing; only reset leaves it.
- alucontrol comes from aluop and funct in the ALU decoder:
  - aluop 00 -> 010 (add)
  - aluop 01 -> 110 (sub)
  - aluop 10 with funct add 100000 -> 010, sub 100010 -> 110, and 100100 -> 000, or 100101 -> 001, slt 101010 -> 111
  - any other funct -> 000

## Timing
- Reset: while reset_n=0, state=FETCH. Gate irwrite, pcwrite, memwrite, regwrite, branch and instr_done to 0 during reset; illegal=0. The first fetch starts on the first rising edge after reset_n rises.
- Reset mid-instruction: state returns to FETCH asynchronously. No partial write is issued after reset_n falls.
- Outputs are combinational from the registered state. The only exception is the mem_ready terms in FETCH and MEMWR. No output depends on op or funct except alucontrol.
- Latency in cycles with mem_ready tied to 1: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3. Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- The memory holds its access for as long as mem_ready=0.

## Structure
- Shared package mips_pkg holds:
  - state enum (4-bit)
  - opcode constants
  - funct constants
  - aluop encodings
  - alusrcb and pcsrc encodings
- Sub-module aludec handles aluop and funct to alucontrol; it is reused unchanged by the single-cycle controller.
- State register and next-state logic live in multicycle_ctrl. Output decode is a single case on the state.

## Test plan
- Reset, then a LW (op=100011) with mem_ready=1: states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5; instr_done pulses once.
- SW with mem_ready held 0 for 3 cycles in MEMWR: memwrite=1 for 4 cycles; instr_done only in the cycle where mem_ready=1; 7 cycles total.
- R-type with funct=101010: alucontrol=111 in EXECUTE; regdst=1 in ALUWB; BEQ then shows branch=1, pcsrc=01, alucontrol=110.
- J: pcwrite=1 and pcsrc=10 in cycle 3. Also apply mem_ready=0 for 2 cycles in FETCH: irwrite=pcwrite=0 until ready.
- Opcode 111111 -> HALT with illegal=1 and no enables for 10 or more cycles; a reset_n pulse clears illegal and restarts FETCH.
- Drop reset_n during MEMWR with memwrite=1: memwrite=0 immediately; state=FETCH after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS controllers: FSM states, opcode/funct fields,
// ALU operation classes and datapath mux selects.
package mips_pkg;

   localparam int unsigned OP_W      = 6;
   localparam int unsigned FUNCT_W   = 6;
   localparam int unsigned ALUCTL_W  = 3;
   localparam int unsigned SEL_W     = 2;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11,
      S_HALT    = 4'd12
   } state_e;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;

   localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
   localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
   localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
   localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
   localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_e;

   localparam logic [ALUCTL_W-1:0] ALUCTL_AND = 3'b000;
   localparam logic [ALUCTL_W-1:0] ALUCTL_OR  = 3'b001;
   localparam logic [ALUCTL_W-1:0] ALUCTL_ADD = 3'b010;
   localparam logic [ALUCTL_W-1:0] ALUCTL_SUB = 3'b110;
   localparam logic [ALUCTL_W-1:0] ALUCTL_SLT = 3'b111;

   localparam logic [SEL_W-1:0] SRCB_REGB  = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;
   localparam logic [SEL_W-1:0] SRCB_IMMSH = 2'b11;

   localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
   localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and memory handshake in,
// enables and mux selects out.
interface multicycle_ctrl_if;
   import mips_pkg::*;

   logic [OP_W-1:0]     op;
   logic [FUNCT_W-1:0]  funct;
   logic                mem_ready;
   logic                iord;
   logic                irwrite;
   logic                pcwrite;
   logic                branch;
   logic [SEL_W-1:0]    pcsrc;
   logic                alusrca;
   logic [SEL_W-1:0]    alusrcb;
   logic [ALUCTL_W-1:0] alucontrol;
   logic                memwrite;
   logic                regwrite;
   logic                regdst;
   logic                memtoreg;
   logic                instr_done;
   logic                illegal;

   // Controller side
   modport master (
      input  op, funct, mem_ready,
      output iord, irwrite, pcwrite, branch, pcsrc, alusrca, alusrcb,
             alucontrol, memwrite, regwrite, regdst, memtoreg, instr_done, illegal
   );

   // Datapath side
   modport slave (
      output op, funct, mem_ready,
      input  iord, irwrite, pcwrite, branch, pcsrc, alusrca, alusrcb,
             alucontrol, memwrite, regwrite, regdst, memtoreg, instr_done, illegal
   );

endinterface

// File: rtl/aludec.sv
// ALU decoder: maps the controller's operation class and the funct field to
// the ALU control code. Shared with the single-cycle controller.
module aludec
   import mips_pkg::*;
(
   input  aluop_e              aluop_i,
   input  logic [FUNCT_W-1:0]  funct_i,
   output logic [ALUCTL_W-1:0] alucontrol_o
);

   always_comb begin
      alucontrol_o = ALUCTL_ADD;
      case (aluop_i)
         ALUOP_ADD: alucontrol_o = ALUCTL_ADD;
         ALUOP_SUB: alucontrol_o = ALUCTL_SUB;
         default: begin
            // Unknown funct codes fall back to AND so the ALU stays benign
            case (funct_i)
               FN_ADD:  alucontrol_o = ALUCTL_ADD;
               FN_SUB:  alucontrol_o = ALUCTL_SUB;
               FN_AND:  alucontrol_o = ALUCTL_AND;
               FN_OR:   alucontrol_o = ALUCTL_OR;
               FN_SLT:  alucontrol_o = ALUCTL_SLT;
               default: alucontrol_o = ALUCTL_AND;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore sequencer for the multicycle MIPS datapath: one state per shared-ALU /
// shared-memory cycle, stalling on the memory-ready handshake.
module multicycle_ctrl
   import mips_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   multicycle_ctrl_if.master ctrl_if
);

   state_e               state_q, state_d;
   aluop_e               aluop_c;
   logic                 iord_c, irwrite_c, pcwrite_c, branch_c;
   logic [SEL_W-1:0]     pcsrc_c, alusrcb_c;
   logic                 alusrca_c, memwrite_c, regwrite_c, regdst_c, memtoreg_c;
   logic                 instr_done_c, illegal_c;
   logic [ALUCTL_W-1:0]  alucontrol_c;

   // State register; reset drops straight back to FETCH, even mid-instruction
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:   if (ctrl_if.mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (ctrl_if.op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_HALT;
            endcase
         end
         S_MEMADR:  state_d = (ctrl_if.op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   if (ctrl_if.mem_ready) state_d = S_MEMWB;
         S_MEMWB:   state_d = S_FETCH;
         S_MEMWR:   if (ctrl_if.mem_ready) state_d = S_FETCH;
         S_EXECUTE: state_d = S_ALUWB;
         S_ALUWB:   state_d = S_FETCH;
         S_BRANCH:  state_d = S_FETCH;
         S_ADDIEX:  state_d = S_ADDIWB;
         S_ADDIWB:  state_d = S_FETCH;
         S_JUMP:    state_d = S_FETCH;
         S_HALT:    state_d = S_HALT;
         default:   state_d = S_FETCH;
      endcase
   end

   // Output decode: everything follows the state except the two mem_ready terms
   always_comb begin
      iord_c       = 1'b0;
      irwrite_c    = 1'b0;
      pcwrite_c    = 1'b0;
      branch_c     = 1'b0;
      pcsrc_c      = PCSRC_ALU;
      alusrca_c    = 1'b0;
      alusrcb_c    = SRCB_REGB;
      aluop_c      = ALUOP_ADD;
      memwrite_c   = 1'b0;
      regwrite_c   = 1'b0;
      regdst_c     = 1'b0;
      memtoreg_c   = 1'b0;
      instr_done_c = 1'b0;
      illegal_c    = 1'b0;
      case (state_q)
         S_FETCH: begin
            alusrcb_c = SRCB_FOUR;
            irwrite_c = ctrl_if.mem_ready;
            pcwrite_c = ctrl_if.mem_ready;
         end
         S_DECODE:  alusrcb_c = SRCB_IMMSH;
         S_MEMADR: begin
            alusrca_c = 1'b1;
            alusrcb_c = SRCB_IMM;
         end
         S_MEMRD:   iord_c = 1'b1;
         S_MEMWB: begin
            regwrite_c   = 1'b1;
            memtoreg_c   = 1'b1;
            instr_done_c = 1'b1;
         end
         S_MEMWR: begin
            iord_c       = 1'b1;
            memwrite_c   = 1'b1;
            instr_done_c = ctrl_if.mem_ready;
         end
         S_EXECUTE: begin
            alusrca_c = 1'b1;
            aluop_c   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            regwrite_c   = 1'b1;
            regdst_c     = 1'b1;
            instr_done_c = 1'b1;
         end
         S_BRANCH: begin
            alusrca_c    = 1'b1;
            aluop_c      = ALUOP_SUB;
            pcsrc_c      = PCSRC_ALUOUT;
            branch_c     = 1'b1;
            instr_done_c = 1'b1;
         end
         S_ADDIEX: begin
            alusrca_c = 1'b1;
            alusrcb_c = SRCB_IMM;
         end
         S_ADDIWB: begin
            regwrite_c   = 1'b1;
            instr_done_c = 1'b1;
         end
         S_JUMP: begin
            pcsrc_c      = PCSRC_JUMP;
            pcwrite_c    = 1'b1;
            instr_done_c = 1'b1;
         end
         S_HALT:    illegal_c = 1'b1;
         default: ;
      endcase
      // No architectural write may leak out while reset is asserted
      if (!reset_n) begin
         irwrite_c    = 1'b0;
         pcwrite_c    = 1'b0;
         memwrite_c   = 1'b0;
         regwrite_c   = 1'b0;
         branch_c     = 1'b0;
         instr_done_c = 1'b0;
         illegal_c    = 1'b0;
      end
   end

   aludec u_aludec (
      .aluop_i      (aluop_c),
      .funct_i      (ctrl_if.funct),
      .alucontrol_o (alucontrol_c)
   );

   assign ctrl_if.iord       = iord_c;
   assign ctrl_if.irwrite    = irwrite_c;
   assign ctrl_if.pcwrite    = pcwrite_c;
   assign ctrl_if.branch     = branch_c;
   assign ctrl_if.pcsrc      = pcsrc_c;
   assign ctrl_if.alusrca    = alusrca_c;
   assign ctrl_if.alusrcb    = alusrcb_c;
   assign ctrl_if.alucontrol = alucontrol_c;
   assign ctrl_if.memwrite   = memwrite_c;
   assign ctrl_if.regwrite   = regwrite_c;
   assign ctrl_if.regdst     = regdst_c;
   assign ctrl_if.memtoreg   = memtoreg_c;
   assign ctrl_if.instr_done = instr_done_c;
   assign ctrl_if.illegal    = illegal_c;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: every cycle's control word is compared against a
// per-instruction step table built from the instruction semantics.
module tb_multicycle_ctrl;

   localparam logic [5:0] T_R    = 6'b000000;
   localparam logic [5:0] T_LW   = 6'b100011;
   localparam logic [5:0] T_SW   = 6'b101011;
   localparam logic [5:0] T_BEQ  = 6'b000100;
   localparam logic [5:0] T_ADDI = 6'b001000;
   localparam logic [5:0] T_J    = 6'b000010;
   localparam logic [5:0] T_BAD  = 6'b111111;

   logic clk;
   logic reset_n;
   int   nvec;
   int   nerr;

   multicycle_ctrl_if bus ();

   multicycle_ctrl dut (
      .clk     (clk),
      .reset_n (reset_n),
      .ctrl_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [17:0] obs_word();
      return {bus.iord, bus.irwrite, bus.pcwrite, bus.branch, bus.pcsrc, bus.alusrca,
              bus.alusrcb, bus.alucontrol, bus.memwrite, bus.regwrite, bus.regdst,
              bus.memtoreg, bus.instr_done, bus.illegal};
   endfunction

   function automatic logic [2:0] alu_ref(input logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b000;
      endcase
   endfunction

   // Cycle count of each instruction with no memory stalls (illegal: fetch+decode then halt)
   function automatic int n_steps(input logic [5:0] o);
      case (o)
         T_LW:               return 5;
         T_SW, T_R, T_ADDI:  return 4;
         T_BEQ, T_J:         return 3;
         default:            return 2;
      endcase
   endfunction

   function automatic logic is_wait(input logic [5:0] o, input int k);
      return (k == 0) || (((o == T_LW) || (o == T_SW)) && (k == 3));
   endfunction

   // Expected controls for step k of an instruction with opcode o
   function automatic logic [17:0] exp_word(input logic [5:0] o, input logic [5:0] f,
                                            input int k, input logic mr);
      logic iord, irw, pcw, br, asa, mw, rw, rd, m2r, done, ill;
      logic [1:0] pcs, asb;
      logic [2:0] ac;
      {iord, irw, pcw, br, asa, mw, rw, rd, m2r, done, ill} = 11'd0;
      pcs = 2'b00; asb = 2'b00; ac = 3'b010;
      if (k == 0) begin
         irw = mr; pcw = mr; asb = 2'b01;
      end else if (k == 1) begin
         asb = 2'b11;
      end else begin
         case (o)
            T_LW: begin
               if (k == 2) begin asa = 1'b1; asb = 2'b10; end
               else if (k == 3) iord = 1'b1;
               else begin rw = 1'b1; m2r = 1'b1; done = 1'b1; end
            end
            T_SW: begin
               if (k == 2) begin asa = 1'b1; asb = 2'b10; end
               else begin iord = 1'b1; mw = 1'b1; done = mr; end
            end
            T_R: begin
               if (k == 2) begin asa = 1'b1; ac = alu_ref(f); end
               else begin rw = 1'b1; rd = 1'b1; done = 1'b1; end
            end
            T_ADDI: begin
               if (k == 2) begin asa = 1'b1; asb = 2'b10; end
               else begin rw = 1'b1; done = 1'b1; end
            end
            T_BEQ: begin
               asa = 1'b1; ac = 3'b110; pcs = 2'b01; br = 1'b1; done = 1'b1;
            end
            T_J: begin
               pcs = 2'b10; pcw = 1'b1; done = 1'b1;
            end
            default: ill = 1'b1;
         endcase
      end
      return {iord, irw, pcw, br, pcs, asa, asb, ac, mw, rw, rd, m2r, done, ill};
   endfunction

   function automatic logic [5:0] pick_op(input int s);
      case (s)
         0:       return T_R;
         1:       return T_LW;
         2:       return T_SW;
         3:       return T_BEQ;
         4:       return T_ADDI;
         default: return T_J;
      endcase
   endfunction

   function automatic logic [5:0] pick_funct(input int s);
      case (s)
         0:       return 6'b100000;
         1:       return 6'b100010;
         2:       return 6'b100100;
         3:       return 6'b100101;
         4:       return 6'b101010;
         default: return 6'($urandom);
      endcase
   endfunction

   task automatic check(input string tag, input logic [17:0] exp);
      logic [17:0] o;
      o = obs_word();
      nvec++;
      assert (o === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, o, exp);
      end
   endtask

   // One clock: drive mem_ready, compare mid-cycle, then advance past the edge
   task automatic step(input string tag, input logic [5:0] o, input logic [5:0] f,
                       input int k, input logic mr);
      bus.mem_ready = mr;
      @(negedge clk);
      check($sformatf("%s_k%0d", tag, k), exp_word(o, f, k, mr));
      @(posedge clk);
      #1;
   endtask

   // fs / ms: not-ready cycles in FETCH / in the data access
   task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                            input int fs, input int ms);
      int   k;
      int   stall;
      int   guard;
      int   n;
      logic mr;
      k = 0; stall = 0; guard = 0;
      n = n_steps(o);
      bus.op = o;
      bus.funct = f;
      while ((k < n) && (guard < 64)) begin
         if (is_wait(o, k)) mr = (stall >= ((k == 0) ? fs : ms));
         else               mr = 1'($urandom);
         step(tag, o, f, k, mr);
         guard++;
         if (is_wait(o, k) && !mr) stall++;
         else begin
            k++;
            stall = 0;
         end
      end
   endtask

   initial begin
      logic [5:0] f;
      nvec = 0;
      nerr = 0;
      reset_n = 1'b0;
      bus.op = T_LW;
      bus.funct = 6'd0;
      bus.mem_ready = 1'b1;
      repeat (2) @(negedge clk) check("reset", exp_word(T_LW, 6'd0, 0, 1'b0));
      @(posedge clk);
      #1 reset_n = 1'b1;

      run_instr("lw",        T_LW,   6'b100000, 0, 0);
      run_instr("sw_stall",  T_SW,   6'($urandom), 0, 3);
      run_instr("r_slt",     T_R,    6'b101010, 0, 0);
      run_instr("beq",       T_BEQ,  6'($urandom), 0, 0);
      run_instr("j_fstall",  T_J,    6'($urandom), 2, 0);
      run_instr("lw_stall",  T_LW,   6'($urandom), 1, 2);
      run_instr("addi",      T_ADDI, 6'($urandom), 0, 0);
      for (int i = 0; i < 6; i++) run_instr("r_funct", T_R, pick_funct(i), 0, 0);

      for (int i = 0; i < 60; i++) begin
         run_instr("rand", pick_op(int'($urandom_range(0, 5))),
                   pick_funct(int'($urandom_range(0, 6))),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      // Reset while a store is holding memwrite
      f = 6'($urandom);
      bus.op = T_SW;
      bus.funct = f;
      step("sw_abort", T_SW, f, 0, 1'b1);
      step("sw_abort", T_SW, f, 1, 1'b1);
      step("sw_abort", T_SW, f, 2, 1'b1);
      bus.mem_ready = 1'b0;
      @(negedge clk);
      check("sw_abort_memwr", exp_word(T_SW, f, 3, 1'b0));
      #2 reset_n = 1'b0;
      #1 check("sw_abort_async", exp_word(T_SW, f, 0, 1'b0));
      bus.mem_ready = 1'b1;
      @(negedge clk);
      check("sw_abort_held", exp_word(T_SW, f, 0, 1'b0));
      @(posedge clk);
      #1 reset_n = 1'b1;
      run_instr("after_abort", T_LW, 6'($urandom), 0, 1);

      // Unsupported opcode halts until reset
      f = 6'($urandom);
      run_instr("illegal", T_BAD, f, 1, 0);
      for (int i = 0; i < 12; i++) step("halt_hold", T_BAD, f, 2, 1'($urandom));
      bus.mem_ready = 1'b1;
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1 check("halt_reset", exp_word(T_BAD, f, 0, 1'b0));
      @(posedge clk);
      #1 reset_n = 1'b1;
      run_instr("after_halt", T_ADDI, 6'($urandom), 0, 0);
      run_instr("after_halt", T_BEQ, 6'($urandom), 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
